// File: rtl/rot_amt_finder32.sv
// Sequential inverse of the 32-bit rotator: finds the smallest right rotation k
// with rotr(a,k)==y and reports it in rotator encoding (lr=1 left, lr=0 right).
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// busy then stays high until done. done pulses for exactly one cycle, and
// found/amt/lr are valid from done until the next accepted start.
module rot_amt_finder32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [4:0]   amt,
  output logic         lr
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] cur;
  logic [W-1:0] y_reg;
  logic [4:0]   cnt;
  logic         match;
  logic         last;
  logic [5:0]   neg_k;

  assign match = (cur == y_reg);
  assign last  = (cnt == 5'd31);
  // Left amount for k>16 is 32-k, which always fits in 5 bits (1..15).
  assign neg_k = 6'd32 - {1'b0, cnt};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_SEARCH;
      S_SEARCH: if (match || last) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SEARCH: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Search datapath: one compare per edge, rotating the captured word right by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur   <= '0;
      y_reg <= '0;
      cnt   <= '0;
      found <= 1'b0;
      amt   <= '0;
      lr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur   <= a;
            y_reg <= y;
            cnt   <= '0;
            found <= 1'b0;
            amt   <= '0;
            lr    <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (match) begin
            found <= 1'b1;
            if (cnt <= 5'd16) begin
              lr  <= 1'b0;
              amt <= cnt;
            end else begin
              lr  <= 1'b1;
              amt <= neg_k[4:0];
            end
          end else if (last) begin
            found <= 1'b0;
            amt   <= '0;
            lr    <= 1'b0;
          end else begin
            cur <= {cur[0], cur[W-1:1]};
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
